// File: rtl/symcounter_pkg.sv
// symcounter_pkg: shared FSM states, LFSR taps and 7-segment hex patterns for the symbol-counting game
package symcounter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Active-low {dp,g,f,e,d,c,b,a}; all segments off
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // One Galois step: shift right, fold the dropped bit back through the taps
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Hex digit to active-low segment pattern
    function automatic logic [7:0] seg_hex(input logic [3:0] v);
        logic [7:0] p;
        case (v)
            4'h0: p = SEG_0;
            4'h1: p = SEG_1;
            4'h2: p = SEG_2;
            4'h3: p = SEG_3;
            4'h4: p = SEG_4;
            4'h5: p = SEG_5;
            4'h6: p = SEG_6;
            4'h7: p = SEG_7;
            4'h8: p = SEG_8;
            4'h9: p = SEG_9;
            4'hA: p = SEG_A;
            4'hB: p = SEG_B;
            4'hC: p = SEG_C;
            4'hD: p = SEG_D;
            4'hE: p = SEG_E;
            default: p = SEG_F;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sym_seg_decode.sv
// sym_seg_decode: 4-bit value to active-low 7-segment pattern {dp,g..a}
module sym_seg_decode
    import symcounter_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [7:0] seg_o
);

    assign seg_o = seg_hex(val_i);

endmodule

// File: rtl/sym_gen.sv
// sym_gen: LFSR symbol generator with special-symbol count; SYM_GEN_SEG_EN enables the segment decoder
module sym_gen
    import symcounter_pkg::*;
#(
    parameter int          NUM_SYMS    = 10,
    parameter logic [3:0]  SPECIAL_SYM = 4'd7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        Clk100M,
    input  logic        Rst_n,
    input  logic        startGen,
    input  logic        stopGen,
    input  logic [31:0] symGenMax,
    output logic        genActive,
    output logic        symValid,
    output logic [3:0]  symbol,
    output logic [7:0]  specialCount,
    output logic [7:0]  symSeg
);

    localparam logic [4:0] NS = 5'(NUM_SYMS);

    state_e      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  sym_q, sym_d;
    logic        valid_q, valid_d;
    logic [7:0]  spec_q, spec_d;

    logic [15:0] lfsr_nx;
    logic [3:0]  nib;
    logic [3:0]  sym_r;
    logic        emit;

    assign lfsr_nx = lfsr_step(lfsr_q);
    assign nib     = lfsr_nx[3:0];
    // Fold out-of-range nibbles back into the alphabet with a single subtract
    assign sym_r   = ({1'b0, nib} < NS) ? nib : nib - NS[3:0];
    assign emit    = (state_q == RUN) && (cnt_q == period_q - 32'd1);

    // Next state: stop beats start, start (re)arms the period, RUN emits on period wrap
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        sym_d    = sym_q;
        valid_d  = 1'b0;
        spec_d   = spec_q;
        if (stopGen) begin
            state_d = IDLE;
        end else if (startGen) begin
            state_d  = RUN;
            period_d = (symGenMax < 32'd2) ? 32'd2 : symGenMax;
            cnt_d    = 32'd0;
            spec_d   = 8'd0;
        end else if (state_q == RUN) begin
            cnt_d = emit ? 32'd0 : cnt_q + 32'd1;
            if (emit) begin
                lfsr_d  = lfsr_nx;
                sym_d   = sym_r;
                valid_d = 1'b1;
                spec_d  = (sym_r == SPECIAL_SYM && spec_q != 8'hFF) ? spec_q + 8'd1 : spec_q;
            end
        end
    end

    // State registers
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            period_q <= 32'd2;
            cnt_q    <= 32'd0;
            lfsr_q   <= LFSR_SEED;
            sym_q    <= 4'd0;
            valid_q  <= 1'b0;
            spec_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            sym_q    <= sym_d;
            valid_q  <= valid_d;
            spec_q   <= spec_d;
        end
    end

    assign genActive    = (state_q == RUN);
    assign symValid     = valid_q;
    assign symbol       = sym_q;
    assign specialCount = spec_q;

`ifdef SYM_GEN_SEG_EN
    logic       have_q;
    logic [7:0] seg_w;

    // Display stays blank from reset until a symbol has actually been produced
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            have_q <= 1'b0;
        end else begin
            have_q <= have_q | valid_d;
        end
    end

    sym_seg_decode u_seg (
        .val_i (sym_q),
        .seg_o (seg_w)
    );

    assign symSeg = have_q ? seg_w : SEG_BLANK;
`else
    assign symSeg = SEG_BLANK;
`endif

endmodule

// File: tb/tb_sym_gen.sv
// tb_sym_gen: table-driven and randomized checks of sym_gen against a polynomial-level LFSR model
module tb_sym_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] gmax = 32'd0;
    logic        act;
    logic        vld;
    logic [3:0]  sym;
    logic [7:0]  cnt;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    sym_gen dut (
        .Clk100M      (clk),
        .Rst_n        (rst_n),
        .startGen     (start),
        .stopGen      (stop),
        .symGenMax    (gmax),
        .genActive    (act),
        .symValid     (vld),
        .symbol       (sym),
        .specialCount (cnt),
        .symSeg       (seg)
    );

    int total = 0;
    int passed = 0;

    logic [15:0] m_lfsr;
    int          m_cnt;
    logic [3:0]  m_sym;

    typedef struct {
        logic [31:0] g;
        int          p;
        int          n;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Mask derived from the polynomial exponents 16,14,13,11
    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] mask;
        int          ex[4] = '{16, 14, 13, 11};
        logic        out;
        mask = '0;
        foreach (ex[i]) mask[ex[i]-1] = 1'b1;
        out = s[0];
        s = s >> 1;
        return out ? (s ^ mask) : s;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] g);
        gmax = g;
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_cnt = 0;
        chk("start_active", 32'(act), 32'd1);
        chk("start_count", 32'(cnt), 32'd0);
    endtask

    task automatic run_syms(input int p, input int n);
        for (int s = 0; s < n; s++) begin
            int k = 0;
            int v;
            do begin
                cyc();
                k++;
            end while (!vld && k <= p + 4);
            if (!vld) begin
                chk("strobe_timeout", 32'(k), 32'(p));
                return;
            end
            m_lfsr = m_step(m_lfsr);
            v = int'(m_lfsr[3:0]);
            m_sym = 4'(v % 10);
            if (m_sym == 4'd7 && m_cnt < 255) m_cnt++;
            chk("interval", 32'(k), 32'(p));
            chk("symbol", 32'(sym), 32'(m_sym));
            chk("special_count", 32'(cnt), 32'(m_cnt));
        end
    endtask

    task automatic quiet(input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (vld) seen++;
        end
        chk("quiet_no_strobe", 32'(seen), 32'd0);
    endtask

    task automatic stop_check();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_active", 32'(act), 32'd0);
        chk("stop_valid", 32'(vld), 32'd0);
        chk("stop_symbol_hold", 32'(sym), 32'(m_sym));
        chk("stop_count_hold", 32'(cnt), 32'(m_cnt));
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_active"}, 32'(act), 32'd0);
        chk({nm, "_valid"}, 32'(vld), 32'd0);
        chk({nm, "_symbol"}, 32'(sym), 32'd0);
        chk({nm, "_count"}, 32'(cnt), 32'd0);
        chk({nm, "_seg"}, 32'(seg), 32'hFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        m_lfsr = 16'hACE1;
        m_sym = 4'd0;
        m_cnt = 0;
        tbl[0] = '{32'd50, 50, 4};
        tbl[1] = '{32'd0, 2, 5};
        tbl[2] = '{32'd1, 2, 5};
        tbl[3] = '{32'd2, 2, 3};
        tbl[4] = '{32'd3, 3, 3};
        tbl[5] = '{32'd17, 17, 3};
        for (int i = 6; i < 8; i++) begin
            g = int'($urandom_range(0, 12));
            tbl[i] = '{32'(g), (g < 2) ? 2 : g, int'($urandom_range(2, 6))};
        end

        #2;
        chk_reset_outs("in_reset");
        #21;
        rst_n = 1'b1;
        quiet(50);
        chk_reset_outs("idle50");

        for (int i = 0; i < 8; i++) begin
            start_run(tbl[i].g);
            run_syms(tbl[i].p, tbl[i].n);
            if (i % 2 == 1) begin
                stop_check();
                quiet(2 * tbl[i].p + 3);
            end
        end

        start_run(32'd2);
        run_syms(2, 300);
        stop_check();
        quiet(10);

        start_run(32'd4);
        run_syms(4, 2);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        chk("both_active", 32'(act), 32'd0);
        chk("both_valid", 32'(vld), 32'd0);
        quiet(12);
        start_run(32'd3);
        run_syms(3, 4);

        start_run(32'd5);
        run_syms(5, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async_reset");
        #3;
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        m_sym = 4'd0;
        m_cnt = 0;
        cyc();
        chk_reset_outs("after_reset");
        start_run(32'd6);
        run_syms(6, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
